// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe: valid/ready on both sides
// plus the packed result and its exception flags.
interface fp_mul_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_ovf;
  logic         flag_unf;
  logic         flag_inv;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flag_ovf, flag_unf, flag_inv
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flag_ovf, flag_unf, flag_inv
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage parametrised floating-point multiplier: classify/exponent,
// mantissa product, then normalise/round-to-nearest-even/pack with flags.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_mul_pipe_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int MW = MAN_W + 1;
  localparam int PW = 2 * MAN_W + 2;

  localparam logic [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {
    KIND_NUM,
    KIND_ZERO,
    KIND_INF,
    KIND_NAN
  } kind_e;

  // ---------------------------------------------------------------------------
  // Handshake: every stage moves together whenever the output slot is free.
  // ---------------------------------------------------------------------------
  logic out_valid_q;
  logic advance;

  assign advance      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = advance;

  // ---------------------------------------------------------------------------
  // S1: operand classification and biased exponent sum
  // ---------------------------------------------------------------------------
  logic               a_sign, b_sign;
  logic [EXP_W-1:0]   a_exp, b_exp;
  logic [MAN_W-1:0]   a_frac, b_frac;
  logic               a_zero, a_inf, a_nan;
  logic               b_zero, b_inf, b_nan;

  assign a_sign = bus.a[W-1];
  assign b_sign = bus.b[W-1];
  assign a_exp  = bus.a[W-2 -: EXP_W];
  assign b_exp  = bus.b[W-2 -: EXP_W];
  assign a_frac = bus.a[MAN_W-1:0];
  assign b_frac = bus.b[MAN_W-1:0];

  // Subnormal inputs are flushed: any zero exponent is treated as zero.
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (&a_exp) && (a_frac == '0);
  assign b_inf  = (&b_exp) && (b_frac == '0);
  assign a_nan  = (&a_exp) && (a_frac != '0);
  assign b_nan  = (&b_exp) && (b_frac != '0);

  kind_e            s1_kind_d;
  logic             s1_sign_d;
  logic [EW-1:0]    s1_exp_d;
  logic [MW-1:0]    s1_ma_d, s1_mb_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    s1_kind_d = KIND_NUM;
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
      s1_kind_d = KIND_NAN;
    end else if (a_inf || b_inf) begin
      s1_kind_d = KIND_INF;
    end else if (a_zero || b_zero) begin
      s1_kind_d = KIND_ZERO;
    end
  end

  assign s1_sign_d = a_sign ^ b_sign;
  assign s1_exp_d  = {2'b00, a_exp} + {2'b00, b_exp} - BIAS;
  assign s1_ma_d   = {1'b1, a_frac};
  assign s1_mb_d   = {1'b1, b_frac};

  logic             s1_valid_q;
  kind_e            s1_kind_q;
  logic             s1_sign_q;
  logic [EW-1:0]    s1_exp_q;
  logic [MW-1:0]    s1_ma_q, s1_mb_q;

  // ---------------------------------------------------------------------------
  // S2: full-width mantissa product
  // ---------------------------------------------------------------------------
  logic [PW-1:0]    s2_prod_d;

  assign s2_prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);

  logic             s2_valid_q;
  kind_e            s2_kind_q;
  logic             s2_sign_q;
  logic [EW-1:0]    s2_exp_q;
  logic [PW-1:0]    s2_prod_q;

  // Valid bits carry the pipeline state, so they alone need the reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all stages sample pre-edge values.
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else if (advance) begin
      s1_valid_q <= bus.in_valid;
      s2_valid_q <= s1_valid_q;
    end
  end

  // NOTE: datapath registers are deliberately not reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_kind_q <= s1_kind_d;
      s1_sign_q <= s1_sign_d;
      s1_exp_q  <= s1_exp_d;
      s1_ma_q   <= s1_ma_d;
      s1_mb_q   <= s1_mb_d;
      s2_kind_q <= s1_kind_q;
      s2_sign_q <= s1_sign_q;
      s2_exp_q  <= s1_exp_q;
      s2_prod_q <= s2_prod_d;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: normalise, round to nearest even, detect range errors, pack
  // ---------------------------------------------------------------------------
  logic [PW-1:0]    norm;
  logic [EW-1:0]    e_norm, e_rnd;
  logic [MAN_W-1:0] frac_trunc;
  logic             guard, sticky, round_up;
  logic [MAN_W:0]   frac_rnd;

  // The product of two [1,2) mantissas lies in [1,4); align its leading one to the top bit.
  assign norm       = s2_prod_q[PW-1] ? s2_prod_q : (s2_prod_q << 1);
  assign e_norm     = s2_exp_q + EW'(s2_prod_q[PW-1]);
  assign frac_trunc = norm[PW-2 -: MAN_W];
  assign guard      = norm[MAN_W];
  assign sticky     = |norm[MAN_W-1:0];
  assign round_up   = guard && (sticky || frac_trunc[0]);
  assign frac_rnd   = {1'b0, frac_trunc} + (MAN_W+1)'(round_up);
  // A rounding carry leaves the fraction field at zero and bumps the exponent.
  assign e_rnd      = e_norm + EW'(frac_rnd[MAN_W]);

  logic [W-1:0]     res_d;
  logic             ovf_d, unf_d, inv_d;

  always_comb begin
    res_d = {s2_sign_q, e_rnd[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inv_d = 1'b0;
    unique case (s2_kind_q)
      KIND_NAN: begin
        res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        inv_d = 1'b1;
      end
      KIND_INF:  res_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      KIND_ZERO: res_d = {s2_sign_q, {(W-1){1'b0}}};
      KIND_NUM: begin
        // e_rnd is two's complement; the sign bit marks a negative exponent.
        if (!e_rnd[EW-1] && (e_rnd >= EXP_MAX)) begin
          res_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_d = 1'b1;
        end else if (e_rnd[EW-1] || (e_rnd == '0)) begin
          res_d = {s2_sign_q, {(W-1){1'b0}}};
          unf_d = 1'b1;
        end
      end
    endcase
  end

  logic [W-1:0] result_q;
  logic         flag_ovf_q, flag_unf_q, flag_inv_q;

  // Output registers hold while stalled; bubbles leave the last payload untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flag_ovf_q  <= 1'b0;
      flag_unf_q  <= 1'b0;
      flag_inv_q  <= 1'b0;
    end else if (advance) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        result_q   <= res_d;
        flag_ovf_q <= ovf_d;
        flag_unf_q <= unf_d;
        flag_inv_q <= inv_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flag_ovf  = flag_ovf_q;
  assign bus.flag_unf  = flag_unf_q;
  assign bus.flag_inv  = flag_inv_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe: single precision streams with and without
// backpressure, mid-stream reset, and a half-precision instance.
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23)) sp_if ();
  fp_mul_pipe_if #(.EXP_W(5), .MAN_W(10)) hp_if ();

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) u_dut_sp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sp_if.slave)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) u_dut_hp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hp_if.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Single-precision vectors; expected flags are {ovf, unf, inv}.
  localparam int NV = 13;
  logic [31:0] va [NV] = '{32'h3FC00000, 32'h3F800001, 32'h3FFFFFFF, 32'h7F000000,
                           32'h80800000, 32'h7F800000, 32'hFF800000, 32'h7F800001,
                           32'h00000000, 32'h00000001, 32'h40400000, 32'h3F800001,
                           32'h3F800003};
  logic [31:0] vb [NV] = '{32'h40000000, 32'h3F800001, 32'h3FFFFFFF, 32'h7F000000,
                           32'h3F000000, 32'h00000000, 32'h40000000, 32'h3F800000,
                           32'hC0000000, 32'h40000000, 32'hC0800000, 32'h3FC00000,
                           32'h3FC00000};
  logic [31:0] vr [NV] = '{32'h40400000, 32'h3F800002, 32'h407FFFFE, 32'h7F800000,
                           32'h80000000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000,
                           32'h80000000, 32'h00000000, 32'hC1400000, 32'h3FC00002,
                           32'h3FC00004};
  logic [2:0]  vf [NV] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b000,
                           3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};

  typedef struct {
    logic [34:0] val;
    int          cyc;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;
  int   cyc      = 0;
  int   cur_idx  = 0;
  bit   acc_seen = 1'b0;
  bit   lat_en   = 1'b0;

  // Monitor: samples on the falling edge, compares against the queue head
  // every cycle the output is valid (so stalled values are checked too).
  always @(negedge clk) begin
    cyc++;
    acc_seen = 1'b0;
    if (rst_n) begin
      check("in_ready", 64'(sp_if.in_ready), 64'(!(sp_if.out_valid && !sp_if.out_ready)));
      if (sp_if.out_valid) begin
        if (sb.size() == 0) begin
          check("spurious out_valid", 64'd1, 64'd0);
        end else begin
          check("result", {29'd0, sp_if.flag_ovf, sp_if.flag_unf, sp_if.flag_inv, sp_if.result},
                64'(sb[0].val));
          if (sp_if.out_ready) begin
            if (lat_en) check("latency", 64'(cyc - sb[0].cyc), 64'd3);
            void'(sb.pop_front());
          end
        end
      end
      if (sp_if.in_valid && sp_if.in_ready) begin
        acc_seen    = 1'b1;
        mon_e.val   = {vf[cur_idx], vr[cur_idx]};
        mon_e.cyc   = cyc;
        sb.push_back(mon_e);
      end
    end
  end

  task automatic drive_vec(input int idx);
    cur_idx  = idx;
    sp_if.a  = va[idx];
    sp_if.b  = vb[idx];
  endtask

  // Streams cnt consecutive vectors; toggle selects out_ready pattern 1,0,0,1,0,0...
  task automatic run_stream(input int first, input int cnt, input bit toggle);
    int sent   = 0;
    int t      = 0;
    int budget = 0;
    @(posedge clk); #1;
    sp_if.out_ready = 1'b1;
    drive_vec(first);
    sp_if.in_valid = 1'b1;
    while ((sent < cnt || sb.size() != 0) && budget < 400) begin
      @(posedge clk); #1;
      budget++;
      t++;
      sp_if.out_ready = toggle ? (t % 3 == 0) : 1'b1;
      if (sent < cnt && acc_seen) begin
        sent++;
        if (sent < cnt) drive_vec(first + sent);
        else sp_if.in_valid = 1'b0;
      end
    end
    check("stream drained in budget", 64'(budget < 400), 64'd1);
    sp_if.out_ready = 1'b1;
  endtask

  task automatic hp_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] r, input logic [2:0] f);
    int lat = 0;
    @(posedge clk); #1;
    hp_if.in_valid  = 1'b1;
    hp_if.a         = a;
    hp_if.b         = b;
    hp_if.out_ready = 1'b1;
    @(posedge clk); #1;
    hp_if.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!hp_if.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("hp latency", 64'(lat), 64'd3);
    check("hp result", {45'd0, hp_if.flag_ovf, hp_if.flag_unf, hp_if.flag_inv, hp_if.result},
          {45'd0, f, r});
  endtask

  initial begin
    rst_n           = 1'b0;
    sp_if.in_valid  = 1'b0;
    sp_if.a         = '0;
    sp_if.b         = '0;
    sp_if.out_ready = 1'b1;
    hp_if.in_valid  = 1'b0;
    hp_if.a         = '0;
    hp_if.b         = '0;
    hp_if.out_ready = 1'b1;

    #1;
    check("reset out_valid", 64'(sp_if.out_valid), 64'd0);
    check("reset result", 64'(sp_if.result), 64'd0);
    check("reset flags", 64'({sp_if.flag_ovf, sp_if.flag_unf, sp_if.flag_inv}), 64'd0);
    check("reset hp out_valid", 64'(hp_if.out_valid), 64'd0);
    #22;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after reset", 64'(sp_if.in_ready), 64'd1);

    // Back-to-back with no backpressure: every result must take exactly 3 cycles.
    lat_en = 1'b1;
    run_stream(0, NV, 1'b0);
    lat_en = 1'b0;

    // Six consecutive products under the 1,0,0 out_ready pattern.
    run_stream(0, 6, 1'b1);

    // Mid-stream reset with three accepted operations in flight.
    @(posedge clk); #1;
    sp_if.out_ready = 1'b1;
    drive_vec(0);
    sp_if.in_valid = 1'b1;
    @(posedge clk); #1;
    drive_vec(1);
    @(posedge clk); #1;
    drive_vec(2);
    @(posedge clk); #1;
    sp_if.in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", 64'(sp_if.out_valid), 64'd0);
    check("async reset result", 64'(sp_if.result), 64'd0);
    check("async reset flags", 64'({sp_if.flag_ovf, sp_if.flag_unf, sp_if.flag_inv}), 64'd0);
    sb.delete();
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no stale output", 64'(sp_if.out_valid), 64'd0);
    end

    // Half precision instance.
    hp_op(16'h3E00, 16'h4000, 16'h4200, 3'b000);
    hp_op(16'h7BFF, 16'h7BFF, 16'h7C00, 3'b100);
    hp_op(16'h7C00, 16'h0000, 16'h7E00, 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point multiplier. Successor to the team's single-precision combinational multiplier.
- Adds configurable exponent/mantissa widths, a 3-stage pipeline with valid/ready backpressure, and round-to-nearest-even.
- Handles zero, infinity, NaN, overflow and underflow, with exception flags.
- Sits between operand FIFOs and the accumulator datapath.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block accepts operands this cycle
a  input  W  operand A {sign, exp, frac}
b  input  W  operand B
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  W  product
flag_ovf  output  1  overflow (result forced to ±inf); valid with out_valid
flag_unf  output  1  underflow (result flushed to ±0); valid with out_valid
flag_inv  output  1  invalid (0×inf or NaN operand); valid with out_valid

Behaviour:
- Reset (rst_n low, async): all stage valid bits 0, out_valid=0, result=0, all flags 0. in_ready=1 combinationally once reset is released. Reset mid-operation discards in-flight data.
- Pipeline stages:
  - S1: classify operands, XOR signs, exponent sum E = ea+eb-bias as signed EXP_W+2 bits.
  - S2: (MAN_W+1)×(MAN_W+1) unsigned product of {1,frac} terms.
  - S3: normalise, round, pack, flags; drives the output registers.
- Latency: exactly 3 cycles from accept to out_valid when unstalled. Throughput 1/cycle.
- Handshake:
  - advance = !out_valid | out_ready; in_ready = advance.
  - Accept occurs when in_valid & in_ready. All stages shift together when advance=1 and hold when advance=0.
  - Bubbles propagate as valid=0.
  - result and flags remain stable while out_valid & !out_ready.
- Classification:
  - exp==0 means zero; subnormals are treated as zero (DAZ).
  - exp all-ones with frac==0 means inf; exp all-ones with frac!=0 means NaN.
- Special priority (highest first):
  - NaN operand, or zero×inf: canonical quiet NaN {0, all-ones, 1 followed by zeros}, flag_inv=1.
  - Else inf operand: {sign, all-ones, 0}.
  - Else zero operand: {sign, 0, 0}, no flags.
- Normalisation:
  - Product P is 2*MAN_W+2 bits. If P MSB=1: take fraction from P below MSB, E+=1. Else shift left by 1.
  - Guard = next bit below the fraction LSB; sticky = OR of all remaining lower bits.
- Rounding: round-to-nearest-even. Increment if guard & (sticky | frac LSB). A carry out of the fraction sets frac=0 and E+=1.
- Overflow: final E >= 2^EXP_W-1 gives {sign, all-ones, 0}, flag_ovf=1.
- Underflow: final E <= 0 gives {sign, 0, 0}, flag_unf=1. No subnormal output.
- Simultaneous accept and output handshake in one cycle is legal and must not drop or duplicate data.

Test Plan:
- Basic: a=0x3FC00000 (1.5), b=0x40000000 (2.0), out_ready=1 -> 3 cycles later result=0x40400000, all flags 0.
- Rounding: a=b=0x3F800001 -> result=0x3F800002 (1+2^-22; the 2^-46 term rounds down). Also 0x3FFFFFFF×0x3FFFFFFF -> 0x407FFFFE.
- Exceptions:
  - 0x7F000000×0x7F000000 -> 0x7F800000, flag_ovf=1.
  - 0x80800000×0x3F000000 -> 0x80000000, flag_unf=1.
  - 0x7F800000×0x00000000 -> 0x7FC00000, flag_inv=1.
  - 0xFF800000×0x40000000 -> 0xFF800000, no flags.
- Backpressure: stream 6 consecutive products with out_ready toggling 1,0,0,1,... -> results in order with no loss or duplication; result held stable while stalled; in_ready=0 exactly when out_valid & !out_ready.
- Reset mid-stream: assert rst_n=0 with 3 operations in flight -> out_valid=0 and result=0 immediately (async); after release, no stale result ever appears.
- Parameter sweep: EXP_W=5, MAN_W=10 (half precision): 0x3E00 (1.5) × 0x4000 (2.0) -> 0x4200; 0x7BFF×0x7BFF -> 0x7C00 with flag_ovf=1.
